// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
//   Scan controller for a 4x4 Pmod keypad. It drives one column low at a time,
//   samples the rows once per column after a settle delay, and debounces
//   whole-scan results. Each clean press becomes a single key-code event in a
//   small FIFO, which the consumer drains with a valid/ready handshake.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   en         : scan enable (0 parks the scanner; FIFO keeps working)
//   row[3:0]   : keypad rows, active-low
//   col[3:0]   : keypad column drive, active-low, at most one low
//   key_code   : key code at the FIFO head (0 when empty)
//   key_valid  : FIFO not empty
//   key_ready  : consumer accepts the head entry
//   key_held   : a debounced single key is currently pressed
//   fifo_count : number of entries in the FIFO
//   overflow   : 1-cycle pulse when a press is dropped on a full FIFO
// ---------------------------------------------------------------------------
module keypad_scan_ctrl #(
  parameter int COL_TICKS      = 100000,
  parameter int SETTLE_TICKS   = 100,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [3:0]                    row,
  output logic [3:0]                    col,
  output logic [3:0]                    key_code,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          key_held,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int TW = (COL_TICKS > 1) ? $clog2(COL_TICKS) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_e;

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b1000 >> c);
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] k;
    case ({c, r})
      4'h0: k = 4'h1;  4'h1: k = 4'h4;  4'h2: k = 4'h7;  4'h3: k = 4'h0;
      4'h4: k = 4'h2;  4'h5: k = 4'h5;  4'h6: k = 4'h8;  4'h7: k = 4'hF;
      4'h8: k = 4'h3;  4'h9: k = 4'h6;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
      4'hC: k = 4'hA;  4'hD: k = 4'hB;  4'hE: k = 4'hC;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Scan state
  logic [TW-1:0] r_tick;
  logic [1:0]    r_c;
  logic [3:0]    r_col;
  logic [1:0]    r_hits;      // 0, 1, or 2 meaning "two or more"
  logic [3:0]    r_acc_key;
  res_e          r_cand;
  logic [3:0]    r_cand_key;
  logic [DW-1:0] r_cnt;
  logic          r_latch;
  logic          r_held;

  // FIFO state
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_tick_last;
  logic          w_sample;
  logic          w_scan_end;
  logic          w_row_hit;
  logic          w_row_multi;
  logic [1:0]    w_row_idx;
  res_e          w_res;
  logic          w_match;
  logic [DW-1:0] w_cnt_next;
  logic          w_stable;
  logic          w_push;
  logic          w_release;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;

  assign w_tick_last = (r_tick == TW'(COL_TICKS - 1));
  assign w_sample    = (r_tick == TW'(SETTLE_TICKS));
  assign w_scan_end  = en & w_tick_last & (r_c == 2'd3);

  always_comb begin
    w_row_hit   = 1'b0;
    w_row_multi = 1'b0;
    w_row_idx   = 2'd0;
    case (row)
      4'b0111: begin w_row_hit = 1'b1; w_row_idx = 2'd0; end
      4'b1011: begin w_row_hit = 1'b1; w_row_idx = 2'd1; end
      4'b1101: begin w_row_hit = 1'b1; w_row_idx = 2'd2; end
      4'b1110: begin w_row_hit = 1'b1; w_row_idx = 2'd3; end
      4'b1111: ;
      default: w_row_multi = 1'b1;
    endcase
  end

  // Whole-scan result and debounce bookkeeping for the scan-end edge
  always_comb begin
    w_res = RES_MULTI;
    if (r_hits == 2'd0)      w_res = RES_NONE;
    else if (r_hits == 2'd1) w_res = RES_KEY;
    w_match    = (w_res == r_cand) && ((w_res != RES_KEY) || (r_acc_key == r_cand_key));
    w_cnt_next = DW'(1);
    if (w_match)
      w_cnt_next = (r_cnt == DW'(DEBOUNCE_SCANS)) ? r_cnt : r_cnt + DW'(1);
    w_stable  = (w_cnt_next == DW'(DEBOUNCE_SCANS));
    w_push    = w_scan_end & w_stable & (w_res == RES_KEY) & ~r_latch;
    w_release = w_scan_end & w_stable & (w_res == RES_NONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick     <= '0;
      r_c        <= 2'd0;
      r_col      <= 4'b1111;
      r_hits     <= 2'd0;
      r_acc_key  <= 4'h0;
      r_cand     <= RES_NONE;
      r_cand_key <= 4'h0;
      r_cnt      <= '0;
      r_latch    <= 1'b0;
      r_held     <= 1'b0;
    end else if (!en) begin
      r_tick     <= '0;
      r_c        <= 2'd0;
      r_col      <= 4'b1111;
      r_hits     <= 2'd0;
      r_acc_key  <= 4'h0;
      r_cand     <= RES_NONE;
      r_cand_key <= 4'h0;
      r_cnt      <= '0;
      r_latch    <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      if (w_tick_last) begin
        r_tick <= '0;
        r_c    <= r_c + 2'd1;
      end else begin
        r_tick <= r_tick + TW'(1);
      end
      // Column drive is registered and switches on the same edge as r_c.
      r_col <= col_drive(w_tick_last ? r_c + 2'd1 : r_c);

      if (w_scan_end) begin
        r_hits     <= 2'd0;
        r_acc_key  <= 4'h0;
        r_cand     <= w_res;
        r_cand_key <= r_acc_key;
        r_cnt      <= w_cnt_next;
        if (w_push) begin
          r_latch <= 1'b1;
          r_held  <= 1'b1;
        end else if (w_release) begin
          r_latch <= 1'b0;
          r_held  <= 1'b0;
        end
      end else if (w_sample) begin
        if (w_row_multi) begin
          r_hits <= 2'd2;
        end else if (w_row_hit) begin
          if (r_hits == 2'd0) begin
            r_hits    <= 2'd1;
            r_acc_key <= key_map(r_c, w_row_idx);
          end else begin
            r_hits <= 2'd2;
          end
        end
      end
    end
  end

  // Key-event FIFO; a push on a full FIFO still lands if the head pops.
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = (r_count != '0) & key_ready;
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_acc_key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= ptr_inc(r_wptr);
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_overflow <= w_push & w_full & ~w_pop;
    end
  end

  assign col        = r_col;
  assign key_valid  = (r_count != '0);
  assign key_code   = key_valid ? r_mem[r_rptr] : 4'h0;
  assign key_held   = r_held;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//   Bench for keypad_scan_ctrl. A keypad emulation pulls rows low from the
//   driven column and a set of pressed keys. A reference model tracks the scan
//   position arithmetically, counts pressed keys seen per scan, applies the
//   debounce rules and keeps the FIFO as a queue.
// ---------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

  localparam int CT    = 20;
  localparam int ST    = 4;
  localparam int DB    = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        key_ready;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic [15:0] pressed;

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_seen = 0;

  // Reference model state
  int         m_n;
  int         m_hits;
  int         m_cand_kind;  // 0 none, 1 key, 2 multi
  int         m_cnt;
  logic [3:0] m_key;
  logic [3:0] m_cand_key;
  logic [3:0] m_col;
  bit         m_latch;
  bit         m_held;
  bit         m_ovf;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .COL_TICKS(CT), .SETTLE_TICKS(ST), .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .fifo_count(fifo_count), .overflow(overflow)
  );

  function automatic logic [3:0] kmap(input int c, input int r);
    logic [3:0] k;
    case (c * 4 + r)
      0: k = 4'h1;   1: k = 4'h4;   2: k = 4'h7;   3: k = 4'h0;
      4: k = 4'h2;   5: k = 4'h5;   6: k = 4'h8;   7: k = 4'hF;
      8: k = 4'h3;   9: k = 4'h6;  10: k = 4'h9;  11: k = 4'hE;
      12: k = 4'hA; 13: k = 4'hB;  14: k = 4'hC;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [3:0] kp_rows(input logic [3:0] colv, input logic [15:0] pr);
    logic [3:0] rv;
    rv = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!colv[3-c])
        for (int r = 0; r < 4; r++)
          if (pr[kmap(c, r)]) rv[3-r] = 1'b0;
    return rv;
  endfunction

  assign row = kp_rows(col, pressed);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
  endtask

  task automatic model_reset();
    m_n = 0; m_hits = 0; m_cand_kind = 0; m_cnt = 0;
    m_key = 4'h0; m_cand_key = 4'h0; m_col = 4'hF;
    m_latch = 0; m_held = 0; m_ovf = 0;
    q.delete();
  endtask

  task automatic model_edge();
    bit pop, push, full;
    int tick, c, nlow, kind;
    logic [3:0] pk;
    pop  = (q.size() != 0) && key_ready;
    full = (q.size() == DEPTH);
    push = 0;
    pk   = 4'h0;
    m_ovf = 0;
    if (!en) begin
      m_n = 0; m_hits = 0; m_cand_kind = 0; m_cnt = 0; m_cand_key = 4'h0;
      m_latch = 0; m_held = 0; m_col = 4'hF;
    end else begin
      tick = m_n % CT;
      c    = (m_n / CT) % 4;
      if (tick == ST) begin
        nlow = 0;
        for (int r = 0; r < 4; r++)
          if (pressed[kmap(c, r)]) begin
            nlow++;
            m_key = kmap(c, r);
          end
        m_hits += nlow;
      end
      if (tick == CT - 1 && c == 3) begin
        kind = (m_hits == 0) ? 0 : (m_hits == 1) ? 1 : 2;
        if (kind == m_cand_kind && (kind != 1 || m_key == m_cand_key)) begin
          if (m_cnt < DB) m_cnt++;
        end else begin
          m_cand_kind = kind;
          m_cand_key  = m_key;
          m_cnt       = 1;
        end
        if (m_cnt == DB) begin
          if (kind == 1 && !m_latch) begin
            push = 1; pk = m_key; m_latch = 1; m_held = 1;
          end else if (kind == 0) begin
            m_latch = 0; m_held = 0;
          end
        end
        m_hits = 0;
      end
      m_n   = (m_n + 1) % (4 * CT);
      m_col = ~(4'b1000 >> ((m_n / CT) % 4));
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (!full || pop) q.push_back(pk);
      else m_ovf = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    check("col", col, m_col);
    check("key_valid", key_valid, q.size() != 0);
    if (q.size() != 0) check("key_code", key_code, q[0]);
    check("key_held", key_held, m_held);
    check("fifo_count", fifo_count, q.size());
    check("overflow", overflow, m_ovf);
    if (overflow) ovf_seen++;
  endtask

  task automatic run_scans(input int n);
    repeat (n * 4 * CT) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, col, 4'hF);
    check({tag, "_code"}, key_code, 4'h0);
    check({tag, "_valid"}, key_valid, 1'b0);
    check({tag, "_held"}, key_held, 1'b0);
    check({tag, "_count"}, fifo_count, 3'd0);
    check({tag, "_ovf"}, overflow, 1'b0);
  endtask

  initial begin
    logic [3:0] exp_drain [4];
    int seg_len, mode, p_ready;
    exp_drain[0] = 4'h1; exp_drain[1] = 4'h2; exp_drain[2] = 4'h3; exp_drain[3] = 4'h4;

    rst = 1'b0; en = 1'b0; key_ready = 1'b0; pressed = 16'h0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst0");
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    en  = 1'b1;

    // 1: hold key 5, single push after three scans, no repeat
    pressed = 16'h0020;
    run_scans(2);
    check("t1_before", fifo_count, 3'd0);
    run_scans(1);
    check("t1_push", fifo_count, 3'd1);
    run_scans(7);
    check("t1_count", fifo_count, 3'd1);
    check("t1_code", key_code, 4'h5);
    check("t1_held", key_held, 1'b1);

    // 2: release, press D, drain 5 then D
    pressed = 16'h0;
    run_scans(2);
    check("t2_held_still", key_held, 1'b1);
    run_scans(1);
    check("t2_released", key_held, 1'b0);
    pressed = 16'h2000;
    run_scans(3);
    check("t2_count", fifo_count, 3'd2);
    key_ready = 1'b1;
    check("t2_pop0", key_code, 4'h5);
    step();
    check("t2_pop1", key_code, 4'hD);
    step();
    check("t2_empty", key_valid, 1'b0);
    key_ready = 1'b0;

    // 3: bouncing key 7
    pressed = 16'h0;
    run_scans(3);
    for (int i = 0; i < 8; i++) begin
      pressed = (i % 2 == 0) ? 16'h0080 : 16'h0;
      run_scans(1);
    end
    check("t3_count", fifo_count, 3'd0);
    check("t3_held", key_held, 1'b0);

    // 4: key 1 held, then 1 and 2 together
    pressed = 16'h0002;
    run_scans(3);
    check("t4_push", fifo_count, 3'd1);
    pressed = 16'h0006;
    run_scans(5);
    check("t4_count", fifo_count, 3'd1);
    check("t4_held", key_held, 1'b1);
    pressed = 16'h0;
    run_scans(3);
    check("t4_release", key_held, 1'b0);
    key_ready = 1'b1;
    repeat (2) step();
    key_ready = 1'b0;

    // 5: five presses into a four-deep FIFO
    ovf_seen = 0;
    foreach (exp_drain[i]) begin
      pressed = 16'h1 << exp_drain[i];
      run_scans(3);
      pressed = 16'h0;
      run_scans(3);
    end
    pressed = 16'h0040;
    run_scans(3);
    pressed = 16'h0;
    run_scans(3);
    check("t5_count", fifo_count, 3'd4);
    check("t5_ovf_pulses", ovf_seen, 1);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_drain", key_code, exp_drain[i]);
      step();
    end
    check("t5_empty", key_valid, 1'b0);
    key_ready = 1'b0;

    // 6: disable mid-column 2 with key 9 at debounce count 2
    pressed = 16'h0200;
    run_scans(2);
    for (int i = 0; i < 4 * CT && m_n != 2 * CT + 10; i++) step();
    en = 1'b0;
    step();
    check("t6_col_off", col, 4'hF);
    repeat (5) step();
    en = 1'b1;
    run_scans(2);
    check("t6_no_push", fifo_count, 3'd0);
    run_scans(1);
    check("t6_push", fifo_count, 3'd1);
    check("t6_code", key_code, 4'h9);
    repeat (30) step();
    #2 rst = 1'b1;
    #1 check_reset_outputs("t6_async");
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    pressed = 16'h0;

    // Randomized segments
    for (int s = 0; s < 60; s++) begin
      mode = $urandom_range(0, 9);
      if (mode <= 2)      pressed = 16'h0;
      else if (mode <= 7) pressed = 16'h1 << $urandom_range(0, 15);
      else if (mode == 8) pressed = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      en      = ($urandom_range(0, 19) != 0);
      p_ready = $urandom_range(0, 100);
      seg_len = $urandom_range(20, 200);
      for (int i = 0; i < seg_len; i++) begin
        key_ready = ($urandom_range(0, 99) < p_ready);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 Pmod keypad. It sequences column drive and row sampling, debounces whole-scan results, and turns each clean press into one key-code event. Events go into a small FIFO that the downstream consumer drains through a valid/ready handshake. It sits between the keypad pins and the application logic, such as a display or an entry register.

Parameters:
COL_TICKS, 100000, clock cycles each column is driven (1 ms at 100 MHz); must be greater than SETTLE_TICKS+1
SETTLE_TICKS, 100, cycles after column drive before rows are sampled (1 us at 100 MHz)
DEBOUNCE_SCANS, 3, consecutive identical full-scan results required to accept a state change; minimum 1
FIFO_DEPTH, 4, key-event FIFO entries; must be a power of 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  scan enable
row  input  4  keypad row inputs, active-low
col  output  4  keypad column drive, active-low, one-hot-zero
key_code  output  4  key code at the FIFO head
key_valid  output  1  FIFO not empty
key_ready  input  1  consumer accepts the head entry
key_held  output  1  a debounced single key is currently pressed
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of entries in the FIFO
overflow  output  1  1-cycle pulse when a press event is dropped because the FIFO is full

Behaviour:
- Reset values: col=4'b1111, key_code=0, key_valid=0, key_held=0, fifo_count=0, overflow=0. The scan index, tick counter, debounce state and FIFO are all cleared.
- Scan sequencing:
  - Column index c runs 0..3 and drives col = 0111, 1011, 1101, 1110 respectively.
  - A tick counter counts 0..COL_TICKS-1 for each column.
  - At the edge where tick==COL_TICKS-1, c advances and wraps 3->0; col is registered and changes on that same edge.
  - Rows are sampled once per column, at the edge where tick==SETTLE_TICKS.
- Column sample result:
  - row equal to 0111, 1011, 1101 or 1110 is one hit.
  - row equal to 1111 is no hit.
  - Any other pattern counts as a multi hit.
- Key map:
  - c0: rows 0111/1011/1101/1110 map to 1, 4, 7, 0.
  - c1: rows map to 2, 5, 8, F.
  - c2: rows map to 3, 6, 9, E.
  - c3: rows map to A, B, C, D.
- Scan result: evaluated at the edge ending column 3.
  - NONE if there were 0 hits across all columns.
  - KEY(k) if there was exactly 1 hit.
  - MULTI otherwise.
- Debounce:
  - A candidate register and a counter that saturates at DEBOUNCE_SCANS.
  - If the result equals the candidate, the counter increments; otherwise candidate=result and count=1.
  - The candidate becomes stable when count reaches DEBOUNCE_SCANS.
- Stable-state actions, taken on the same scan-end edge:
  - Stable KEY(k) while not latched: push k, set the pressed latch, set key_held=1.
  - Stable KEY(k) while latched: nothing happens. There is no auto-repeat, and a change to a different stable key also pushes nothing.
  - Stable NONE: clear the latch and set key_held=0.
  - MULTI: never pushes, never stable-releases, and leaves the latch and key_held unchanged.
- FIFO:
  - Pop occurs on key_valid & key_ready.
  - key_code shows the head entry; key_valid = (count != 0).
  - A push becomes visible at key_valid/key_code on the cycle after the push edge.
  - Push with pop in the same cycle, including when full: both occur and the count is unchanged.
  - Push when full with no pop: the new key is dropped, overflow pulses for 1 cycle, and the FIFO contents are unchanged.
  - Pop when empty is ignored.
- en=0:
  - Next edge: col=1111; tick, c, candidate, count, latch and key_held are cleared.
  - The FIFO and handshake keep operating.
  - When en is reasserted, scanning restarts at c=0, tick=0.
- Asynchronous rst mid-scan or mid-handshake: all state clears immediately, including FIFO contents.

Test Plan:
(Benches use COL_TICKS=20, SETTLE_TICKS=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4, giving an 80-cycle scan.)
1. Hold key 5 (row=1011 while col=1011, else 1111) for 10 scans with key_ready=0. Required: exactly one push at the end of scan 3; key_valid=1, key_code=5, fifo_count=1 throughout; key_held=1.
2. Release, then press D (col=1110, row=1110) for 3 scans. Required: key_held falls after 3 NONE scans, then D is pushed. With key_ready=1, two pops follow: first 5, then D, then key_valid=0.
3. Bounce: key 7 toggles present/absent every scan for 8 scans. Required: no push, key_held=0.
4. Keys 1 and 2 both held for 5 scans. Required: MULTI result, no push, key_held unchanged, fifo_count unchanged.
5. With key_ready=0, do 5 clean press/release cycles of keys 1, 2, 3, 4, 6. Required: fifo_count=4 and overflow pulses 1 cycle on the 6-push. Draining then yields 1, 2, 3, 4.
6. Deassert en mid-column 2 while key 9 has debounce count 2. Required: col=1111 next cycle. After reassertion, 3 full new scans are needed before 9 is pushed. Then assert rst mid-scan: all outputs return to reset values immediately.
